// File: rtl/isa_pkg.sv
// ISA definitions for the 4-bit computer's instruction sequencer.
// Holds the opcode map, sequencer state encoding, ALU op codes, instruction
// field positions and the decoded control bundle shared by decoder and sequencer.
package isa_pkg;

   localparam int ISA_WORD_W = 10;
   localparam int ISA_ADDR_W = 4;
   localparam int ISA_DATA_W = 4;

   // Instruction fields: [9:6] opcode, [5] reserved, [4] register select, [3:0] imm/target
   localparam int OPC_MSB    = 9;
   localparam int OPC_LSB    = 6;
   localparam int REGSEL_BIT = 4;
   localparam int IMM_MSB    = 3;
   localparam int IMM_LSB    = 0;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDI = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_AND = 4'h4,
      OP_MOV = 4'h5,
      OP_JMP = 4'h6,
      OP_JZ  = 4'h7,
      OP_JC  = 4'h8,
      OP_OUT = 4'h9,
      OP_HLT = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} seq_state_t;

   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_PASS} alu_op_t;

   typedef struct packed {
      logic                  reg_wr;
      logic                  reg_sel;
      logic                  imm_sel;
      logic [ISA_DATA_W-1:0] imm;
      alu_op_t               alu_op;
      logic                  out_en;
      logic                  jmp;
      logic                  jz;
      logic                  jc;
      logic                  hlt;
   } ctrl_bundle_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   ir      in   instruction register contents
//   ctrl    out  decoded control bundle (strobe requests are unqualified by state)
//   illegal out  opcode is in the undefined range (A-E); bundle is then a NOP
module instr_decoder
   import isa_pkg::*;
(
   input  logic [ISA_WORD_W-1:0] ir,
   output ctrl_bundle_t          ctrl,
   output logic                  illegal
);

   // Bit 5 is reserved and carries no meaning to the decoder.
   logic unused_rsvd;
   assign unused_rsvd = ir[5];

   always_comb begin
      ctrl     = '0;
      illegal  = 1'b0;
      ctrl.imm = ir[IMM_MSB:IMM_LSB];
      case (opcode_t'(ir[OPC_MSB:OPC_LSB]))
         OP_NOP: ;
         OP_LDI: begin
            ctrl.reg_wr  = 1'b1;
            ctrl.imm_sel = 1'b1;
            ctrl.reg_sel = ir[REGSEL_BIT];
         end
         OP_ADD: begin ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_ADD;  end
         OP_SUB: begin ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_SUB;  end
         OP_AND: begin ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_AND;  end
         OP_MOV: begin ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_PASS; end // B -> A
         OP_JMP: ctrl.jmp    = 1'b1;
         OP_JZ:  ctrl.jz     = 1'b1;
         OP_JC:  ctrl.jc     = 1'b1;
         OP_OUT: ctrl.out_en = 1'b1;
         OP_HLT: ctrl.hlt    = 1'b1;
         default: illegal    = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit computer.
// Each instruction takes FETCH -> DECODE -> EXEC (3 cycles); HLT parks in HALT.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   run                   sequence when 1, stall at FETCH when 0
//   prog                  instruction word at the current PC
//   zeroFlag, carryFlag   ALU flags, sampled during EXEC for JZ/JC
//   pcInc, pcLoad         PC requests (one-cycle, EXEC only, mutually exclusive)
//   pcLoadVal, immVal     jump target / immediate (held between instructions)
//   regWrEn, regSel, immSel, aluOp   register-file write control
//   outEn                 latch A into output port
//   halted, illegalOp     status (illegalOp sticky until reset)
module instr_sequencer
   import isa_pkg::*;
#(
   parameter int WORD_W = 10,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [WORD_W-1:0] prog,
   input  logic              zeroFlag,
   input  logic              carryFlag,
   output logic              pcInc,
   output logic              pcLoad,
   output logic [ADDR_W-1:0] pcLoadVal,
   output logic              regWrEn,
   output logic              regSel,
   output logic              immSel,
   output logic [DATA_W-1:0] immVal,
   output logic [1:0]        aluOp,
   output logic              outEn,
   output logic              halted,
   output logic              illegalOp
);

   seq_state_t   state, nxt;
   logic [ISA_WORD_W-1:0] ir;
   ctrl_bundle_t dec, ctrl_q;
   logic         dec_ill, ill_cur, ill_q;
   logic         taken;

   instr_decoder u_dec (
      .ir      (ir),
      .ctrl    (dec),
      .illegal (dec_ill)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH;
         ir      <= '0;
         ctrl_q  <= '0;
         ill_cur <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state <= nxt;
         if (state == FETCH && run) ir <= prog;
         if (state == DECODE) begin
            ctrl_q  <= dec;
            ill_cur <= dec_ill;
         end
         if (state == EXEC && ill_cur) ill_q <= 1'b1;
      end
   end

   // Branch condition uses the flags as seen during EXEC, not at decode time.
   assign taken = ctrl_q.jmp | (ctrl_q.jz & zeroFlag) | (ctrl_q.jc & carryFlag);

   always_comb begin
      nxt     = state;
      pcInc   = 1'b0;
      pcLoad  = 1'b0;
      regWrEn = 1'b0;
      outEn   = 1'b0;
      case (state)
         FETCH:  if (run) nxt = DECODE;
         DECODE: nxt = EXEC;
         EXEC: begin
            nxt     = ctrl_q.hlt ? HALT : FETCH;
            pcLoad  = taken;
            pcInc   = ~taken & ~ctrl_q.hlt;
            regWrEn = ctrl_q.reg_wr;
            outEn   = ctrl_q.out_en;
         end
         HALT:   nxt = HALT;
         default: nxt = FETCH;
      endcase
   end

   // Operand/select outputs come straight from the registered bundle so they
   // stay stable outside EXEC and clear on reset.
   assign pcLoadVal = ctrl_q.imm[ADDR_W-1:0];
   assign immVal    = ctrl_q.imm[DATA_W-1:0];
   assign regSel    = ctrl_q.reg_sel;
   assign immSel    = ctrl_q.imm_sel;
   assign aluOp     = ctrl_q.alu_op;
   assign halted    = (state == HALT);
   // Flag rises during the EXEC of the offending op, then the sticky bit holds it.
   assign illegalOp = ill_q | (state == EXEC && ill_cur);

endmodule
